// File: rtl/spi_adc_pkg.sv
// Shared types and helpers for the SPI ADC master: FSM state encoding and counter sizing.
package spi_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Width of a counter that must hold 0..n-1 (never narrower than one bit)
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_adc_if.sv
// User-side handshake plus ADC pins of the SPI ADC master.
// SPI_ADC_CONT_EN adds the continuous-mode request signal cont.
interface spi_adc_if #(
    parameter int DATA_W = 8,
    parameter int CH_W   = 3
);
    logic              start;
    logic [CH_W-1:0]   ch;
`ifdef SPI_ADC_CONT_EN
    logic              cont;
`endif
    logic              busy;
    logic              data_valid;
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   data_ch;
    logic              cs_n;
    logic              sclk;
    logic              mosi;
    logic              miso;

`ifdef SPI_ADC_CONT_EN
    modport master (input start, ch, cont, miso,
                    output busy, data_valid, data, data_ch, cs_n, sclk, mosi);
    modport slave  (output start, ch, cont, miso,
                    input busy, data_valid, data, data_ch, cs_n, sclk, mosi);
`else
    modport master (input start, ch, miso,
                    output busy, data_valid, data, data_ch, cs_n, sclk, mosi);
    modport slave  (output start, ch, miso,
                    input busy, data_valid, data, data_ch, cs_n, sclk, mosi);
`endif
endinterface

// File: rtl/spi_sclk_div.sv
// Half-period timer for the SPI master: wraps every CLK_DIV cycles while enabled and
// flags which sclk edge the end of the current half-period produces.
module spi_sclk_div
    import spi_adc_pkg::*;
#(
    parameter int CLK_DIV = 12
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic sclk_lvl,
    output logic half_done,
    output logic fall_stb,
    output logic rise_stb
);
    localparam int               CNT_W    = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Divider counter, held at zero while the master is idle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_r <= '0;
        end else if (!en || (cnt_r == CNT_LAST)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign half_done = en && (cnt_r == CNT_LAST);
    assign fall_stb  = half_done && sclk_lvl;
    assign rise_stb  = half_done && !sclk_lvl;

endmodule

// File: rtl/spi_adc_master.sv
// SPI master for serial ADCs: one framed read per accepted start, channel address on MOSI,
// DATA_W-bit sample out with a valid strobe. SPI_ADC_CONT_EN enables round-robin continuous mode.
module spi_adc_master
    import spi_adc_pkg::*;
#(
    parameter int CLK_DIV    = 12,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 3,
    parameter int DATA_W     = 8,
    parameter int CH_W       = 3,
    parameter int CH_POS     = 2,
    parameter int NUM_CH     = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    spi_adc_if.master  bus
);
    localparam int               BIT_W    = cnt_width(FRAME_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    if ((LEAD_BITS + DATA_W > FRAME_BITS) || (CH_POS + CH_W > FRAME_BITS) ||
        (CLK_DIV < 1) || (NUM_CH > (1 << CH_W))) begin : g_bad_params
        $error("spi_adc_master: illegal parameter combination");
    end

    state_e            state_r,   state_s;
    logic [BIT_W-1:0]  bit_r,     bit_s;
    logic [CH_W-1:0]   ch_lat_r,  ch_lat_s;
    logic [DATA_W-1:0] shift_r,   shift_s;
    logic [DATA_W-1:0] data_r,    data_s;
    logic [CH_W-1:0]   data_ch_r, data_ch_s;
    logic              valid_r,   valid_s;
    logic              busy_r,    busy_s;
    logic              cs_n_r,    cs_n_s;
    logic              sclk_r,    sclk_s;
    logic              mosi_r,    mosi_s;
    logic              half_done_s, fall_stb_s, rise_stb_s, in_win_s;

    spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .n_rst     (n_rst),
        .en        (state_r != ST_IDLE),
        .sclk_lvl  (sclk_r),
        .half_done (half_done_s),
        .fall_stb  (fall_stb_s),
        .rise_stb  (rise_stb_s)
    );

    // Address bit for frame bit idx: MSB-first inside the CH_POS window, zero elsewhere
    function automatic logic mosi_for_bit(input int idx, input logic [CH_W-1:0] c);
        logic [CH_W-1:0] sh;
        int              pos;
        pos = idx - CH_POS;
        sh  = c << pos;
        if ((pos >= 0) && (pos < CH_W)) begin
            return sh[CH_W-1];
        end else begin
            return 1'b0;
        end
    endfunction

    assign in_win_s = (int'(bit_r) >= LEAD_BITS) && (int'(bit_r) < LEAD_BITS + DATA_W);

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_s   = state_r;
        bit_s     = bit_r;
        ch_lat_s  = ch_lat_r;
        shift_s   = shift_r;
        data_s    = data_r;
        data_ch_s = data_ch_r;
        valid_s   = 1'b0;
        cs_n_s    = cs_n_r;
        sclk_s    = sclk_r;
        mosi_s    = mosi_r;
        case (state_r)
            ST_IDLE: begin
                cs_n_s = 1'b1;
                sclk_s = 1'b1;
                mosi_s = 1'b0;
                if (bus.start) begin
                    state_s  = ST_SETUP;
                    ch_lat_s = bus.ch;
                    cs_n_s   = 1'b0;
                    bit_s    = '0;
                    shift_s  = '0;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (half_done_s) begin
                    state_s = ST_SHIFT;
                    sclk_s  = 1'b0;
                    bit_s   = '0;
                    mosi_s  = mosi_for_bit(0, ch_lat_r);
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                if (rise_stb_s) begin
                    sclk_s = 1'b1;
                    if (in_win_s) begin
                        shift_s = (shift_r << 1) | DATA_W'(bus.miso);
                    end else begin
                        shift_s = shift_r;
                    end
                end else if (fall_stb_s) begin
                    if (bit_r == BIT_LAST) begin
                        state_s = ST_HOLD;
                        mosi_s  = 1'b0;
                    end else begin
                        bit_s  = bit_r + BIT_W'(1);
                        sclk_s = 1'b0;
                        mosi_s = mosi_for_bit(int'(bit_r) + 1, ch_lat_r);
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (half_done_s) begin
                    state_s   = ST_GAP;
                    cs_n_s    = 1'b1;
                    data_s    = shift_r;
                    data_ch_s = ch_lat_r;
                    valid_s   = 1'b1;
                end else begin
                    state_s   = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (half_done_s) begin
`ifdef SPI_ADC_CONT_EN
                    if (bus.cont) begin
                        state_s  = ST_SETUP;
                        cs_n_s   = 1'b0;
                        bit_s    = '0;
                        shift_s  = '0;
                        ch_lat_s = (ch_lat_r == CH_W'(NUM_CH - 1)) ? '0 : ch_lat_r + CH_W'(1);
                    end else begin
                        state_s  = ST_IDLE;
                    end
`else
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cs_n_s  = 1'b1;
                sclk_s  = 1'b1;
                mosi_s  = 1'b0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= ST_IDLE;
            bit_r     <= '0;
            ch_lat_r  <= '0;
            shift_r   <= '0;
            data_r    <= '0;
            data_ch_r <= '0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            cs_n_r    <= 1'b1;
            sclk_r    <= 1'b1;
            mosi_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bit_r     <= bit_s;
            ch_lat_r  <= ch_lat_s;
            shift_r   <= shift_s;
            data_r    <= data_s;
            data_ch_r <= data_ch_s;
            valid_r   <= valid_s;
            busy_r    <= busy_s;
            cs_n_r    <= cs_n_s;
            sclk_r    <= sclk_s;
            mosi_r    <= mosi_s;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.data_valid = valid_r;
    assign bus.data       = data_r;
    assign bus.data_ch    = data_ch_r;
    assign bus.cs_n       = cs_n_r;
    assign bus.sclk       = sclk_r;
    assign bus.mosi       = mosi_r;

endmodule

// File: tb/tb_spi_adc_master.sv
// Self-checking bench for spi_adc_master: default-parameter instance plus a CLK_DIV=1,
// 12-bit instance, each driven by a behavioural ADC model that replays a frame word.
module tb_spi_adc_master;
    localparam int FB     = 16;
    localparam int CH_W   = 3;
    localparam int CH_POS = 2;
    localparam int NCH    = 8;
    localparam int CD_A   = 12;
    localparam int LEAD_A = 3;
    localparam int DW_A   = 8;
    localparam int CD_B   = 1;
    localparam int LEAD_B = 4;
    localparam int DW_B   = 12;
    localparam int LAT_A  = 1 + CD_A * (2 * FB + 2);
    localparam int LAT_B  = 1 + CD_B * (2 * FB + 2);
    localparam int BOUND  = 3000;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    spi_adc_if #(.DATA_W(DW_A), .CH_W(CH_W)) ia ();
    spi_adc_if #(.DATA_W(DW_B), .CH_W(CH_W)) ib ();

    spi_adc_master #(.CLK_DIV(CD_A), .FRAME_BITS(FB), .LEAD_BITS(LEAD_A), .DATA_W(DW_A),
                     .CH_W(CH_W), .CH_POS(CH_POS), .NUM_CH(NCH))
        u_a (.clk(clk), .n_rst(n_rst), .bus(ia));
    spi_adc_master #(.CLK_DIV(CD_B), .FRAME_BITS(FB), .LEAD_BITS(LEAD_B), .DATA_W(DW_B),
                     .CH_W(CH_W), .CH_POS(CH_POS), .NUM_CH(NCH))
        u_b (.clk(clk), .n_rst(n_rst), .bus(ib));

    int tests = 0;
    int fails = 0;

    // ADC model A: presents frame bits on falling sclk, records mosi on rising sclk
    logic [FB-1:0] frame_a = '0, mosi_word_a = '0;
    logic miso_a = 1'b0, prev_cs_a = 1'b1, prev_sclk_a = 1'b1;
    int fall_a = 0, rise_a = 0, csfall_a = 0, valid_cnt_a = 0;
    assign ia.miso = miso_a;
    always @(ia.cs_n or ia.sclk) begin
        if (prev_cs_a === 1'b1 && ia.cs_n === 1'b0) begin
            fall_a = 0; rise_a = 0; mosi_word_a = '0; csfall_a++;
        end
        if (ia.cs_n === 1'b0 && prev_sclk_a === 1'b1 && ia.sclk === 1'b0 && fall_a < FB) begin
            miso_a = frame_a[FB-1-fall_a]; fall_a++;
        end
        if (ia.cs_n === 1'b0 && prev_sclk_a === 1'b0 && ia.sclk === 1'b1 && rise_a < FB) begin
            mosi_word_a[FB-1-rise_a] = ia.mosi; rise_a++;
        end
        prev_cs_a = ia.cs_n; prev_sclk_a = ia.sclk;
    end
    always @(posedge clk) if (ia.data_valid === 1'b1) valid_cnt_a++;

    // ADC model B, also timestamps the first two sclk rises
    logic [FB-1:0] frame_b = '0;
    logic miso_b = 1'b0, prev_cs_b = 1'b1, prev_sclk_b = 1'b1;
    int fall_b = 0, rise_b = 0;
    time t0_b = 0, t1_b = 0;
    assign ib.miso = miso_b;
    always @(ib.cs_n or ib.sclk) begin
        if (prev_cs_b === 1'b1 && ib.cs_n === 1'b0) begin
            fall_b = 0; rise_b = 0;
        end
        if (ib.cs_n === 1'b0 && prev_sclk_b === 1'b1 && ib.sclk === 1'b0 && fall_b < FB) begin
            miso_b = frame_b[FB-1-fall_b]; fall_b++;
        end
        if (ib.cs_n === 1'b0 && prev_sclk_b === 1'b0 && ib.sclk === 1'b1 && rise_b < FB) begin
            if (rise_b == 0) t0_b = $time;
            if (rise_b == 1) t1_b = $time;
            rise_b++;
        end
        prev_cs_b = ib.cs_n; prev_sclk_b = ib.sclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: sample window and address placement computed straight from the frame layout
    function automatic logic [31:0] ref_data(input logic [31:0] f, input int lead, input int dw);
        return (f >> (FB - lead - dw)) & ((32'd1 << dw) - 32'd1);
    endfunction
    function automatic logic [31:0] ref_mosi(input logic [31:0] c);
        return c << (FB - CH_POS - CH_W);
    endfunction

    task automatic wait_idle_a(input string name);
        int n;
        n = 0;
        while (ia.busy !== 1'b0 && n < BOUND) begin @(posedge clk); #1; n++; end
        check(name, (n < BOUND) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic run_a(input logic [2:0] c, input logic [15:0] f, input logic [31:0] ed);
        int cyc;
        @(negedge clk);
        frame_a = f; ia.ch = c; ia.start = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0; ia.ch = ~c;
        cyc = 1;
        check("busy_on", {31'd0, ia.busy}, 32'd1);
        while (ia.data_valid !== 1'b1 && cyc < BOUND) begin @(posedge clk); #1; cyc++; end
        check("latency_a", cyc, LAT_A);
        check("data_a", {24'd0, ia.data}, ed);
        check("data_ch_a", {29'd0, ia.data_ch}, {29'd0, c});
        check("mosi_a", {16'd0, mosi_word_a}, ref_mosi({29'd0, c}));
        check("sclk_rises_a", rise_a, FB);
        @(posedge clk); #1;
        check("valid_pulse_a", {31'd0, ia.data_valid}, 32'd0);
        repeat (CD_A - 2) @(posedge clk);
        #1 check("busy_last_gap", {31'd0, ia.busy}, 32'd1);
        @(posedge clk); #1;
        check("busy_off", {31'd0, ia.busy}, 32'd0);
        check("cs_n_idle", {31'd0, ia.cs_n}, 32'd1);
    endtask

    task automatic run_b(input logic [15:0] f, input logic [31:0] ed);
        int cyc;
        @(negedge clk);
        frame_b = f; ib.start = 1'b1;
        @(posedge clk); #1;
        ib.start = 1'b0;
        cyc = 1;
        while (ib.data_valid !== 1'b1 && cyc < BOUND) begin @(posedge clk); #1; cyc++; end
        check("latency_b", cyc, LAT_B);
        check("data_b", {20'd0, ib.data}, ed);
        check("sclk_rises_b", rise_b, FB);
        check("sclk_period_b", 32'(t1_b - t0_b), 32'd20);
        @(posedge clk); #1;
        check("busy_off_b", {31'd0, ib.busy}, 32'd0);
    endtask

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] frame;
        logic [7:0]  exp_data;
    } vec_t;
    vec_t tbl[4];

    initial begin
        int v0, c0, n, gap, busy_low;
        logic [2:0]  rc;
        logic [15:0] rf;
        tbl[0] = '{3'd5, 16'b000_10110011_00000, 8'hB3};
        tbl[1] = '{3'd2, 16'b111_01010101_11111, 8'h55};
        tbl[2] = '{3'd7, 16'b101_11110000_01010, 8'hF0};
        tbl[3] = '{3'd0, 16'hFFFF,               8'hFF};
        ia.start = 1'b0; ia.ch = '0; ib.start = 1'b0; ib.ch = '0;
`ifdef SPI_ADC_CONT_EN
        ia.cont = 1'b0; ib.cont = 1'b0;
`endif
        #12;
        check("rst_cs_n", {31'd0, ia.cs_n}, 32'd1);
        check("rst_sclk", {31'd0, ia.sclk}, 32'd1);
        check("rst_mosi", {31'd0, ia.mosi}, 32'd0);
        check("rst_busy", {31'd0, ia.busy}, 32'd0);
        check("rst_valid", {31'd0, ia.data_valid}, 32'd0);
        check("rst_data", {24'd0, ia.data}, 32'd0);
        check("rst_data_ch", {29'd0, ia.data_ch}, 32'd0);
        @(negedge clk); n_rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset during bit 7 aborts the frame without a strobe
        @(negedge clk); frame_a = 16'hFFFF; ia.ch = 3'd3; ia.start = 1'b1;
        @(negedge clk); ia.start = 1'b0;
        n = 0;
        while (fall_a < 8 && n < BOUND) begin @(negedge clk); n++; end
        check("reach_bit7", {31'd0, ia.cs_n}, 32'd0);
        v0 = valid_cnt_a;
        n_rst = 1'b0;
        #1;
        check("abort_cs_n", {31'd0, ia.cs_n}, 32'd1);
        check("abort_sclk", {31'd0, ia.sclk}, 32'd1);
        check("abort_busy", {31'd0, ia.busy}, 32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        check("abort_no_valid", valid_cnt_a - v0, 32'd0);
        check("abort_data", {24'd0, ia.data}, 32'd0);

        for (int i = 0; i < 4; i++) run_a(tbl[i].ch, tbl[i].frame, {24'd0, tbl[i].exp_data});

        for (int i = 0; i < 12; i++) begin
            rc = 3'($urandom_range(0, NCH - 1));
            rf = 16'($urandom);
            run_a(rc, rf, ref_data({16'd0, rf}, LEAD_A, DW_A));
        end

        // Start held high: back-to-back frames with an idle gap of GAP plus one IDLE cycle
        c0 = csfall_a;
        @(negedge clk); frame_a = 16'h1234; ia.ch = 3'd1; ia.start = 1'b1;
        n = 0;
        while (ia.cs_n !== 1'b1 || csfall_a - c0 < 1) begin
            if (n >= BOUND) break;
            @(posedge clk); #1; n++;
        end
        gap = 0;
        while (ia.cs_n === 1'b1 && gap < BOUND) begin @(posedge clk); #1; gap++; end
        check("held_gap", gap, CD_A + 1);
        n = 0;
        while (csfall_a - c0 < 3 && n < 3 * BOUND) begin @(negedge clk); n++; end
        ia.start = 1'b0;
        wait_idle_a("held_idle");
        repeat (30) @(posedge clk);
        check("held_frames", csfall_a - c0, 32'd3);

        // Start pulses while busy are dropped
        c0 = csfall_a;
        @(negedge clk); ia.start = 1'b1;
        @(negedge clk); ia.start = 1'b0;
        repeat (100) @(negedge clk);
        ia.start = 1'b1;
        @(negedge clk); ia.start = 1'b0;
        #1 wait_idle_a("pulse_idle");
        repeat (30) @(posedge clk);
        check("busy_start_ignored", csfall_a - c0, 32'd1);

        run_b({4'b0110, 12'hA5C}, 32'h0A5C);
        for (int i = 0; i < 4; i++) begin
            rf = 16'($urandom);
            run_b(rf, ref_data({16'd0, rf}, LEAD_B, DW_B));
        end

`ifdef SPI_ADC_CONT_EN
        // Continuous mode walks channels and wraps at NCH-1
        c0 = csfall_a;
        busy_low = 0;
        @(negedge clk); ia.cont = 1'b1; ia.ch = 3'd6; ia.start = 1'b1;
        @(posedge clk); #1 ia.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1; n++;
                if (ia.busy !== 1'b1) busy_low++;
            end while (ia.data_valid !== 1'b1 && n < BOUND);
            check("cont_data_ch", {29'd0, ia.data_ch}, (6 + k) % NCH);
            if (k == 2) begin
                n = 0;
                while (ia.cs_n !== 1'b0 && n < BOUND) begin @(posedge clk); #1; n++; end
                ia.cont = 1'b0;
            end
        end
        check("cont_busy_held", busy_low, 32'd0);
        wait_idle_a("cont_idle");
        repeat (30) @(posedge clk);
        check("cont_frames", csfall_a - c0, 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
